// File: rtl/pad_serial_reader.sv
// pad_serial_reader: polls one NES-style controller port.
// Drives pad_latch/pad_clk and shifts in 8 serial bits. It presents them as an
// active-high button byte with a one-cycle valid pulse.
// Optional build macro: PAD_SERIAL_READER_DEBOUNCE_EN. When it is defined,
// the button byte is accepted only when two consecutive polls read the same value.
module pad_serial_reader #(
    parameter int LATCH_CYCLES = 128,
    parameter int HALF_CYCLES  = 64,
    parameter int POLL_CYCLES  = 179000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       pad_latch,
    output logic       pad_clk,
    input  logic       pad_data,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);

    localparam int PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int CNT_W  = $clog2(POLL_CYCLES + 1);

    localparam logic [PH_W-1:0]  LATCH_LOAD = PH_W'(LATCH_CYCLES - 1);
    localparam logic [PH_W-1:0]  HALF_LOAD  = PH_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [PH_W-1:0]  phase_reg, phase_next;
    logic [2:0]       idx_reg, idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       buttons_reg, buttons_next;
    logic             valid_reg, valid_next;
    logic [CNT_W-1:0] poll_cnt_reg, poll_cnt_next;
    logic             req_reg, req_next;
    logic [1:0]       sync_reg;
    logic             pad_latch_reg, pad_latch_next;
    logic             pad_clk_reg, pad_clk_next;
    logic             busy_reg, busy_next;
`ifdef PAD_SERIAL_READER_DEBOUNCE_EN
    logic [7:0]       prev_raw_reg, prev_raw_next;
`endif

    logic wrap;
    logic accept;
    logic phase_last;
    logic sample_en;
    logic sample_bit;

    assign wrap       = (poll_cnt_reg == POLL_LAST);
    assign accept     = (state_reg == ST_IDLE) && enable && (req_reg || wrap);
    assign phase_last = (phase_reg == '0);
    // The pad drives data active-low, so a low level means the button is pressed.
    assign sample_bit = ~sync_reg[1];

    // Per-bit write enables: only the bit selected by the index takes the sample.
    for (genvar gi = 0; gi < 8; gi++) begin : g_shift
        assign shift_next[gi] = (sample_en && (idx_reg == 3'(gi))) ? sample_bit : shift_reg[gi];
    end

    // Two-flop synchronizer for the asynchronous pad data line.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], pad_data};
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            phase_reg     <= '0;
            idx_reg       <= 3'd0;
            shift_reg     <= 8'h00;
            buttons_reg   <= 8'h00;
            valid_reg     <= 1'b0;
            poll_cnt_reg  <= POLL_LAST;
            req_reg       <= 1'b0;
            pad_latch_reg <= 1'b0;
            pad_clk_reg   <= 1'b0;
            busy_reg      <= 1'b0;
`ifdef PAD_SERIAL_READER_DEBOUNCE_EN
            prev_raw_reg  <= 8'h00;
`endif
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            idx_reg       <= idx_next;
            shift_reg     <= shift_next;
            buttons_reg   <= buttons_next;
            valid_reg     <= valid_next;
            poll_cnt_reg  <= poll_cnt_next;
            req_reg       <= req_next;
            pad_latch_reg <= pad_latch_next;
            pad_clk_reg   <= pad_clk_next;
            busy_reg      <= busy_next;
`ifdef PAD_SERIAL_READER_DEBOUNCE_EN
            prev_raw_reg  <= prev_raw_next;
`endif
        end
    end

    // Next-state logic: poll timer, request latch and the latch/shift sequencer.
    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg - PH_W'(1);
        idx_next      = idx_reg;
        buttons_next  = buttons_reg;
        valid_next    = 1'b0;
        sample_en     = 1'b0;
`ifdef PAD_SERIAL_READER_DEBOUNCE_EN
        prev_raw_next = prev_raw_reg;
`endif
        poll_cnt_next = wrap ? '0 : poll_cnt_reg + CNT_W'(1);

        // A request waits for IDLE; disabling polling discards it.
        if (!enable) begin
            req_next = 1'b0;
        end else if (accept) begin
            req_next = 1'b0;
        end else if (wrap) begin
            req_next = 1'b1;
        end else begin
            req_next = req_reg;
        end

        case (state_reg)
            ST_IDLE: begin
                phase_next = phase_reg;
                if (accept) begin
                    state_next = ST_LATCH;
                    phase_next = LATCH_LOAD;
                    idx_next   = 3'd0;
                end
            end
            ST_LATCH: begin
                if (phase_last) begin
                    state_next = ST_LOW;
                    phase_next = HALF_LOAD;
                end
            end
            ST_LOW: begin
                if (phase_last) begin
                    // Sample at the end of the low phase. By then the synchronizer
                    // has settled on the bit shifted out by the previous rising edge.
                    sample_en  = 1'b1;
                    phase_next = HALF_LOAD;
                    state_next = (idx_reg == 3'd7) ? ST_DONE : ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (phase_last) begin
                    state_next = ST_LOW;
                    phase_next = HALF_LOAD;
                    idx_next   = idx_reg + 3'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                phase_next = '0;
`ifdef PAD_SERIAL_READER_DEBOUNCE_EN
                prev_raw_next = shift_reg;
                if (shift_reg == prev_raw_reg) begin
                    buttons_next = shift_reg;
                    valid_next   = 1'b1;
                end
`else
                buttons_next = shift_reg;
                valid_next   = 1'b1;
`endif
            end
            default: begin
                state_next = ST_IDLE;
                phase_next = '0;
            end
        endcase

        pad_latch_next = (state_next == ST_LATCH);
        pad_clk_next   = (state_next == ST_HIGH);
        busy_next      = (state_next != ST_IDLE);
    end

    assign pad_latch = pad_latch_reg;
    assign pad_clk   = pad_clk_reg;
    assign buttons   = buttons_reg;
    assign valid     = valid_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_pad_serial_reader.sv
// tb_pad_serial_reader: directed bench for pad_serial_reader.
// The main instance uses LATCH=4, HALF=4, POLL=200. A second instance uses
// POLL=50, which is shorter than one poll, to check back-to-back polling.
// The bench also holds a behavioural model of the controller shift register.
module tb_pad_serial_reader;

`ifdef PAD_SERIAL_READER_DEBOUNCE_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       pad_latch, pad_clk, pad_data;
    logic [7:0] buttons;
    logic       valid, busy;

    logic       f_latch, f_clk;
    logic [7:0] f_buttons;
    logic       f_valid, f_busy;

    // Controller model.
    logic [7:0] pad_bits = 8'h89;
    logic       pad_force_high = 1'b0;
    logic       glitch_en = 1'b0;
    logic       noise = 1'b0;
    logic [2:0] pad_idx = 3'd0;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    always @(posedge clk) noise <= 1'($urandom_range(0, 1));

    // The latch reloads bit A. Each pad_clk rising edge shifts in the next bit.
    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) pad_idx <= 3'd0;
        else           pad_idx <= pad_idx + 3'd1;
    end

    assign pad_data = pad_force_high ? 1'b1 :
                      (glitch_en && pad_clk) ? noise : ~pad_bits[pad_idx];

    pad_serial_reader #(.LATCH_CYCLES(4), .HALF_CYCLES(4), .POLL_CYCLES(200)) u_dut (
        .clk(clk), .reset(reset), .enable(enable),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .pad_data(pad_data),
        .buttons(buttons), .valid(valid), .busy(busy)
    );

    pad_serial_reader #(.LATCH_CYCLES(4), .HALF_CYCLES(4), .POLL_CYCLES(50)) u_dut_fast (
        .clk(clk), .reset(reset), .enable(enable),
        .pad_latch(f_latch), .pad_clk(f_clk), .pad_data(pad_data),
        .buttons(f_buttons), .valid(f_valid), .busy(f_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else begin
            n_pass++;
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        do begin step(); k++; end while (!valid && k < budget);
        chk(tag, valid, 1);
    endtask

    task automatic wait_latch(input string tag, input int budget);
        int k = 0;
        do begin step(); k++; end while (!pad_latch && k < budget);
        chk(tag, pad_latch, 1);
    endtask

    initial begin
        int r1, r2, rise_n, lat_hi, clk_rises, clk_hi, run, min_run, max_run;
        int busy_n, valid_n, first_valid_t;
        logic [7:0] first_btn;
        logic prev_latch, prev_clk, pf_latch;
        int f_rise_n, f_last, f_bad, f_overlap, vcount, valid_t, lat_cnt, rise_t;

        // Reset state.
        for (int i = 0; i < 3; i++) step();
        chk("rst_latch", pad_latch, 0);
        chk("rst_clk", pad_clk, 0);
        chk("rst_buttons", buttons, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);

        // First polls after reset release: timing and data.
        reset = 1'b0;
        r1 = 0; r2 = 0; rise_n = 0; lat_hi = 0; clk_rises = 0; clk_hi = 0;
        run = 0; min_run = 999; max_run = 0; busy_n = 0; valid_n = 0;
        first_valid_t = 0; first_btn = 8'h00;
        prev_latch = 1'b0; prev_clk = 1'b0; pf_latch = 1'b0;
        f_rise_n = 0; f_last = 0; f_bad = 0; f_overlap = 0;
        for (int c = 1; c <= 400; c++) begin
            step();
            if (pad_latch && !prev_latch) begin
                if (rise_n == 0) r1 = c;
                else if (rise_n == 1) r2 = c;
                rise_n++;
            end
            if (c < 200) begin
                if (pad_latch) lat_hi++;
                if (busy) busy_n++;
                if (pad_clk && !prev_clk) clk_rises++;
                if (pad_clk) begin clk_hi++; run++; end
                if (!pad_clk && prev_clk) begin
                    if (run < min_run) min_run = run;
                    if (run > max_run) max_run = run;
                    run = 0;
                end
            end
            if (valid) begin
                valid_n++;
                if (first_valid_t == 0) begin first_valid_t = c; first_btn = buttons; end
            end
            if (f_latch && !pf_latch) begin
                if (f_rise_n > 0 && (c - f_last) != 66) f_bad++;
                f_last = c;
                f_rise_n++;
            end
            if (f_latch && f_clk) f_overlap++;
            prev_latch = pad_latch; prev_clk = pad_clk; pf_latch = f_latch;
        end
        chk("first_latch_rise", r1, 1);
        chk("second_latch_rise", r2, 201);
        chk("latch_high_cycles", lat_hi, 4);
        chk("pad_clk_rises", clk_rises, 7);
        chk("pad_clk_high_total", clk_hi, 28);
        chk("pad_clk_min_run", min_run, 4);
        chk("pad_clk_max_run", max_run, 4);
        chk("busy_cycles", busy_n, 65);
        chk("valid_count", valid_n, DB ? 1 : 2);
        chk("first_valid_cycle", first_valid_t, DB ? 266 : 66);
        chk("first_buttons", first_btn, 8'h89);
        chk("fast_poll_count", f_rise_n, 7);
        chk("fast_poll_spacing_errs", f_bad, 0);
        chk("fast_latch_clk_overlap", f_overlap, 0);

        // Disconnected pad reads all released.
        pad_force_high = 1'b1;
        wait_valid("float_valid", 600);
        chk("float_buttons", buttons, 8'h00);

        // Noise on pad_data while pad_clk is high must not reach the sample.
        pad_force_high = 1'b0;
        glitch_en = 1'b1;
        pad_bits = 8'h5A;
        wait_valid("glitch_valid", 600);
        chk("glitch_buttons", buttons, 8'h5A);
        glitch_en = 1'b0;
        pad_bits = 8'h89;

        // Reset during the high phase of bit 3.
        wait_latch("s5_latch", 300);
        for (int i = 0; i < 33; i++) step();
        chk("s5_in_high_bit3", pad_clk, 1);
        reset = 1'b1;
        step();
        chk("s5_rst_latch", pad_latch, 0);
        chk("s5_rst_clk", pad_clk, 0);
        chk("s5_rst_buttons", buttons, 8'h00);
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_valid", valid, 0);
        step();
        reset = 1'b0;
        step();
        chk("s5_fresh_latch", pad_latch, 1);
        vcount = 0;
        for (int i = 0; i < 69; i++) begin
            step();
            if (valid) vcount++;
        end
        chk("s5_fresh_valid_count", vcount, DB ? 0 : 1);

        // Dropping enable mid-poll: the poll completes, then polling stops.
        wait_latch("s6_latch", 250);
        for (int t = 2; t <= 10; t++) step();
        enable = 1'b0;
        valid_t = 0;
        for (int t = 11; t <= 100; t++) begin
            step();
            if (valid && valid_t == 0) valid_t = t;
        end
        chk("s6_valid_cycle", valid_t, 66);
        chk("s6_buttons", buttons, 8'h89);
        lat_cnt = 0;
        for (int t = 101; t <= 520; t++) begin
            step();
            if (pad_latch) lat_cnt++;
        end
        chk("s6_no_latch_disabled", lat_cnt, 0);
        enable = 1'b1;
        rise_t = 0;
        for (int t = 521; t <= 700; t++) begin
            step();
            if (pad_latch && rise_t == 0) rise_t = t;
        end
        chk("s6_resume_latch_cycle", rise_t, 601);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
